decoupled_fetch: RTL and testbench

Parametrised fetch stage with an internal fetch queue that decouples I-cache lookup from the instruction buffer. Each cycle it drives `FETCH_WIDTH` sequential PCs to the I-cache, branch predictor and BTB. It enqueues the usable prefix of the returned group, then dequeues up to `OUT_WIDTH` packets per cycle into the instruction buffer. It also tracks miss and queue-full stalls with a small FSM and restarts from the branch stack on misprediction.

---
 rtl/decoupled_fetch_pkg.sv | 32 +++
 rtl/decoupled_fetch_circ_buffer.sv | 63 ++++++
 rtl/decoupled_fetch.sv | 149 ++++++++++++++
 tb/tb_decoupled_fetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoupled_fetch_pkg.sv
// Shared fetch-stage types: instruction/address words, predictor state, queued
// fetch packet, fetch FSM states and the RV32 control-flow opcodes.
package decoupled_fetch_pkg;

   typedef logic [31:0] ADDR;
   typedef logic [31:0] INST;

   typedef struct packed {
      logic [1:0] counter;
      logic [5:0] history;
   } BRANCH_PREDICTOR_PACKET;

   typedef struct packed {
      INST                    inst;
      ADDR                    PC;
      ADDR                    predicted_PC;
      logic                   is_jump;
      logic                   predict_taken;
      BRANCH_PREDICTOR_PACKET bp_packet;
   } FETCH_PACKET;

   typedef enum logic [1:0] {
      FETCH,
      MISS_WAIT,
      FULL_WAIT
   } FETCH_STATE;

   localparam logic [6:0] RV32_BRANCH  = 7'b1100011;
   localparam logic [6:0] RV32_JAL_OP  = 7'b1101111;
   localparam logic [6:0] RV32_JALR_OP = 7'b1100111;

endpackage

// File: rtl/decoupled_fetch_circ_buffer.sv
// Multi-push / multi-pop circular fetch queue; owns head, tail and occupancy.
module fetch_circ_buffer
   import decoupled_fetch_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned PUSH_W = 4,
   parameter int unsigned POP_W  = 4
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              clear,
   input  logic [$clog2(PUSH_W+1)-1:0]       push_num,
   input  FETCH_PACKET                       push_data [PUSH_W],
   input  logic [$clog2(POP_W+1)-1:0]        pop_spots,
   output logic [$clog2(POP_W+1)-1:0]        pop_num,
   output FETCH_PACKET                       pop_data [POP_W],
   output logic [$clog2(DEPTH):0]            count
);
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned POP_CW = $clog2(POP_W + 1);

   FETCH_PACKET      mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;

   always_comb begin
      int unsigned d;
      d = 32'(count);
      if (d > POP_W) d = POP_W;
      if (d > 32'(pop_spots)) d = 32'(pop_spots);
      if (clear) d = 0;
      pop_num = POP_CW'(d);
   end

   // Entries beyond the occupancy read as zero so stale slots never leak out.
   always_comb begin
      for (int unsigned i = 0; i < POP_W; i++) begin
         pop_data[i] = (i < 32'(count)) ? mem[head + PTR_W'(i)] : '0;
      end
   end

   always_ff @(posedge clock) begin
      for (int unsigned i = 0; i < PUSH_W; i++) begin
         if (!reset && !clear && i < 32'(push_num)) begin
            mem[tail + PTR_W'(i)] <= push_data[i];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(pop_num);
         tail  <= tail + PTR_W'(push_num);
         count <= count + CNT_W'(push_num) - CNT_W'(pop_num);
      end
   end

endmodule

// File: rtl/decoupled_fetch.sv
// Fetch stage: drives a PC group to the I-cache/predictors, enqueues the usable
// prefix into a fetch queue and drains it into the instruction buffer.
module decoupled_fetch
   import decoupled_fetch_pkg::*;
#(
   parameter int unsigned FETCH_WIDTH = 4,
   parameter int unsigned OUT_WIDTH   = 4,
   parameter int unsigned QUEUE_DEPTH = 16,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic                              clock,
   input  logic                              reset,
   output ADDR                               PCs_out [FETCH_WIDTH],
   input  INST                               cache_data [FETCH_WIDTH],
   input  logic [FETCH_WIDTH-1:0]            cache_miss,
   input  BRANCH_PREDICTOR_PACKET            bp_packets [FETCH_WIDTH],
   input  logic [FETCH_WIDTH-1:0]            branches_taken,
   input  ADDR                               target_PCs [FETCH_WIDTH],
   input  logic [FETCH_WIDTH-1:0]            btb_hits,
   input  logic                              restore_valid,
   input  ADDR                               PC_restore,
   input  logic [$clog2(OUT_WIDTH+1)-1:0]    inst_buffer_spots,
   output FETCH_PACKET                       inst_buffer_inputs [OUT_WIDTH],
   output logic [$clog2(OUT_WIDTH+1)-1:0]    inst_valid,
   output logic [$clog2(QUEUE_DEPTH):0]      queue_count,
   output logic                              fetch_stall,
   output logic [31:0]                       miss_cycles
);
   localparam int unsigned AW = $clog2(FETCH_WIDTH + 1);
   localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

   ADDR                              pc_reg;
   ADDR                              pc_next;
   FETCH_STATE                       state;
   FETCH_STATE                       state_next;
   logic [FETCH_WIDTH-1:0]           is_branch;
   logic [FETCH_WIDTH-1:0]           is_jump;
   logic [FETCH_WIDTH-1:0]           ptaken;
   logic [AW-1:0]                    accept;
   logic [CW-1:0]                    count;
   logic [CW-1:0]                    count_next;
   logic [$clog2(OUT_WIDTH+1)-1:0]   pop_num;
   FETCH_PACKET                      push_data [FETCH_WIDTH];

   always_comb begin
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         PCs_out[i]   = pc_reg + ADDR'(4 * i);
         is_branch[i] = (cache_data[i][6:0] == RV32_BRANCH);
         is_jump[i]   = (cache_data[i][6:0] == RV32_JAL_OP) ||
                        (cache_data[i][6:0] == RV32_JALR_OP);
         ptaken[i]    = btb_hits[i] && (is_jump[i] || (is_branch[i] && branches_taken[i]));
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         push_data[i].inst          = cache_data[i];
         push_data[i].PC            = PCs_out[i];
         push_data[i].bp_packet     = bp_packets[i];
         push_data[i].is_jump       = is_jump[i];
         push_data[i].predict_taken = ptaken[i];
         push_data[i].predicted_PC  = ptaken[i] ? target_PCs[i] : PCs_out[i] + 32'd4;
      end
   end

   // Group length stops before the first miss and just after the first taken slot.
   always_comb begin
      int unsigned len;
      int unsigned free;
      int unsigned acc;
      logic        stop;
      logic        last_taken;
      ADDR         last_target;
      len         = 0;
      stop        = 1'b0;
      last_taken  = 1'b0;
      last_target = '0;
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         if (!stop) begin
            if (cache_miss[i]) begin
               stop = 1'b1;
            end else begin
               len  = i + 1;
               stop = ptaken[i];
            end
         end
      end
      free = QUEUE_DEPTH - 32'(count);
      acc  = (len < free) ? len : free;
      if (state == FULL_WAIT || restore_valid) acc = 0;
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         if (i + 1 == acc) begin
            last_taken  = ptaken[i];
            last_target = target_PCs[i];
         end
      end
      accept = AW'(acc);

      if (restore_valid)   pc_next = PC_restore;
      else if (last_taken) pc_next = last_target;
      else                 pc_next = pc_reg + ADDR'(4 * acc);

      count_next = restore_valid ? '0 : count + CW'(accept) - CW'(pop_num);

      if (restore_valid)
         state_next = FETCH;
      else if (QUEUE_DEPTH - 32'(count_next) < FETCH_WIDTH)
         state_next = FULL_WAIT;
      else if (cache_miss[0] && state != FULL_WAIT)
         state_next = MISS_WAIT;
      else
         state_next = FETCH;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_reg      <= RESET_PC;
         state       <= FETCH;
         fetch_stall <= 1'b0;
         miss_cycles <= '0;
      end else begin
         pc_reg      <= pc_next;
         state       <= state_next;
         fetch_stall <= (state_next != FETCH);
         if (!restore_valid && state != FULL_WAIT && cache_miss[0] && miss_cycles != '1)
            miss_cycles <= miss_cycles + 32'd1;
      end
   end

   fetch_circ_buffer #(
      .DEPTH  (QUEUE_DEPTH),
      .PUSH_W (FETCH_WIDTH),
      .POP_W  (OUT_WIDTH)
   ) u_queue (
      .clock     (clock),
      .reset     (reset),
      .clear     (restore_valid),
      .push_num  (accept),
      .push_data (push_data),
      .pop_spots (inst_buffer_spots),
      .pop_num   (pop_num),
      .pop_data  (inst_buffer_inputs),
      .count     (count)
   );

   assign inst_valid  = pop_num;
   assign queue_count = count;

endmodule

// File: tb/tb_decoupled_fetch.sv
// Directed bench for decoupled_fetch (FETCH_WIDTH=4, OUT_WIDTH=2, QUEUE_DEPTH=8).
module tb_decoupled_fetch;
   import decoupled_fetch_pkg::*;

   localparam int FW = 4;
   localparam int OW = 2;
   localparam int QD = 8;
   localparam INST NOP    = 32'h0000_0013;
   localparam INST BRANCH = 32'h0000_0063;
   localparam INST JAL    = 32'h0000_006F;

   logic                   clock;
   logic                   reset;
   ADDR                    PCs_out [FW];
   INST                    cache_data [FW];
   logic [FW-1:0]          cache_miss;
   BRANCH_PREDICTOR_PACKET bp_packets [FW];
   logic [FW-1:0]          branches_taken;
   ADDR                    target_PCs [FW];
   logic [FW-1:0]          btb_hits;
   logic                   restore_valid;
   ADDR                    PC_restore;
   logic [1:0]             inst_buffer_spots;
   FETCH_PACKET            inst_buffer_inputs [OW];
   logic [1:0]             inst_valid;
   logic [3:0]             queue_count;
   logic                   fetch_stall;
   logic [31:0]            miss_cycles;

   int checks = 0;
   int errors = 0;

   decoupled_fetch #(
      .FETCH_WIDTH (FW),
      .OUT_WIDTH   (OW),
      .QUEUE_DEPTH (QD),
      .RESET_PC    (32'h0)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .PCs_out            (PCs_out),
      .cache_data         (cache_data),
      .cache_miss         (cache_miss),
      .bp_packets         (bp_packets),
      .branches_taken     (branches_taken),
      .target_PCs         (target_PCs),
      .btb_hits           (btb_hits),
      .restore_valid      (restore_valid),
      .PC_restore         (PC_restore),
      .inst_buffer_spots  (inst_buffer_spots),
      .inst_buffer_inputs (inst_buffer_inputs),
      .inst_valid         (inst_valid),
      .queue_count        (queue_count),
      .fetch_stall        (fetch_stall),
      .miss_cycles        (miss_cycles)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic defaults();
      for (int i = 0; i < FW; i++) begin
         cache_data[i] = NOP;
         bp_packets[i] = BRANCH_PREDICTOR_PACKET'(8'(8'hA0 + i));
         target_PCs[i] = '0;
      end
      cache_miss        = '0;
      branches_taken    = '0;
      btb_hits          = '0;
      restore_valid     = 1'b0;
      PC_restore        = '0;
      inst_buffer_spots = 2'd2;
   endtask

   task automatic do_reset();
      defaults();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      defaults();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_pc0", PCs_out[0], 32'h0);
      check("rst_pc3", PCs_out[3], 32'hC);
      check("rst_count", queue_count, 0);
      check("rst_valid", inst_valid, 0);
      check("rst_stall", fetch_stall, 0);
      check("rst_miss", miss_cycles, 0);
      check("rst_head_zero", 64'(inst_buffer_inputs[0] != '0), 0);

      // 1: straight-line fetch
      check("s1_pc1", PCs_out[1], 32'h4);
      check("s1_pc2", PCs_out[2], 32'h8);
      tick();
      check("s1_pc_next", PCs_out[0], 32'h10);
      check("s1_count", queue_count, 4);
      check("s1_valid", inst_valid, 2);
      check("s1_out0_pc", inst_buffer_inputs[0].PC, 32'h0);
      check("s1_out1_pc", inst_buffer_inputs[1].PC, 32'h4);
      check("s1_out0_ppc", inst_buffer_inputs[0].predicted_PC, 32'h4);
      check("s1_out1_bp", inst_buffer_inputs[1].bp_packet, 8'hA1);
      check("s1_out0_inst", inst_buffer_inputs[0].inst, NOP);
      tick();
      check("s1_count2", queue_count, 6);
      check("s1_out0_pc2", inst_buffer_inputs[0].PC, 32'h8);

      // 2: predicted-taken branch in slot 1
      do_reset();
      cache_data[1]     = BRANCH;
      branches_taken[1] = 1'b1;
      btb_hits[1]       = 1'b1;
      target_PCs[1]     = 32'h100;
      tick();
      defaults();
      check("s2_pc_next", PCs_out[0], 32'h100);
      check("s2_count", queue_count, 2);
      check("s2_out0_taken", inst_buffer_inputs[0].predict_taken, 0);
      check("s2_out1_taken", inst_buffer_inputs[1].predict_taken, 1);
      check("s2_out1_ppc", inst_buffer_inputs[1].predicted_PC, 32'h100);
      check("s2_out1_jump", inst_buffer_inputs[1].is_jump, 0);

      // 2b: jump missing the BTB falls through
      do_reset();
      cache_data[0] = JAL;
      target_PCs[0] = 32'h40;
      tick();
      defaults();
      check("s2b_count", queue_count, 4);
      check("s2b_pc_next", PCs_out[0], 32'h10);
      check("s2b_jump", inst_buffer_inputs[0].is_jump, 1);
      check("s2b_taken", inst_buffer_inputs[0].predict_taken, 0);
      check("s2b_ppc", inst_buffer_inputs[0].predicted_PC, 32'h4);

      // 2c: jump hitting the BTB in slot 2 truncates the group after it
      do_reset();
      cache_data[2] = JAL;
      btb_hits[2]   = 1'b1;
      target_PCs[2] = 32'h80;
      tick();
      defaults();
      check("s2c_count", queue_count, 3);
      check("s2c_pc_next", PCs_out[0], 32'h80);

      // 3: partial miss in slot 2
      do_reset();
      cache_miss = 4'b0100;
      tick();
      defaults();
      check("s3_pc_next", PCs_out[0], 32'h8);
      check("s3_pc1", PCs_out[1], 32'hC);
      check("s3_count", queue_count, 2);
      check("s3_stall", fetch_stall, 0);

      // 4: slot-0 miss held for three cycles
      do_reset();
      cache_miss = 4'b0001;
      tick();
      check("s4_stall1", fetch_stall, 1);
      check("s4_pc_hold1", PCs_out[0], 32'h0);
      check("s4_miss1", miss_cycles, 1);
      check("s4_count1", queue_count, 0);
      tick();
      tick();
      check("s4_miss3", miss_cycles, 3);
      check("s4_pc_hold3", PCs_out[0], 32'h0);
      check("s4_stall3", fetch_stall, 1);
      cache_miss = '0;
      tick();
      check("s4_count_after", queue_count, 4);
      check("s4_stall_after", fetch_stall, 0);
      check("s4_pc_after", PCs_out[0], 32'h10);
      check("s4_miss_final", miss_cycles, 3);

      // 5: queue full
      do_reset();
      inst_buffer_spots = 2'd0;
      tick();
      check("s5_count1", queue_count, 4);
      check("s5_stall1", fetch_stall, 0);
      tick();
      check("s5_count2", queue_count, 8);
      check("s5_stall2", fetch_stall, 1);
      check("s5_pc2", PCs_out[0], 32'h20);
      check("s5_valid_none", inst_valid, 0);
      cache_miss = 4'b0001;
      tick();
      check("s5_full_ignores_miss", miss_cycles, 0);
      check("s5_pc_held", PCs_out[0], 32'h20);
      check("s5_count_held", queue_count, 8);
      cache_miss        = '0;
      inst_buffer_spots = 2'd2;
      #1;
      check("s5_valid_drain", inst_valid, 2);
      tick();
      check("s5_count6", queue_count, 6);
      check("s5_stall6", fetch_stall, 1);
      tick();
      check("s5_count4", queue_count, 4);
      check("s5_stall4", fetch_stall, 0);
      check("s5_pc4", PCs_out[0], 32'h20);

      // 6: redirect with five entries queued
      do_reset();
      inst_buffer_spots = 2'd0;
      tick();
      cache_miss        = 4'b0100;
      inst_buffer_spots = 2'd1;
      tick();
      check("s6_count5", queue_count, 5);
      check("s6_pc", PCs_out[0], 32'h18);
      check("s6_stall", fetch_stall, 1);
      cache_miss        = '0;
      inst_buffer_spots = 2'd2;
      restore_valid     = 1'b1;
      PC_restore        = 32'h200;
      #1;
      check("s6_valid_forced0", inst_valid, 0);
      tick();
      restore_valid = 1'b0;
      #1;
      check("s6_count0", queue_count, 0);
      check("s6_pc_restore", PCs_out[0], 32'h200);
      check("s6_pc_restore1", PCs_out[1], 32'h204);
      check("s6_stall0", fetch_stall, 0);
      check("s6_valid0", inst_valid, 0);

      // 6b: reset wins over a simultaneous redirect
      tick();
      check("s6b_count_pre", queue_count, 4);
      reset         = 1'b1;
      restore_valid = 1'b1;
      PC_restore    = 32'h300;
      tick();
      reset         = 1'b0;
      restore_valid = 1'b0;
      #1;
      check("s6b_pc", PCs_out[0], 32'h0);
      check("s6b_count", queue_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
